div_issue_arbiter: RTL and testbench
====================================

// Module: div_issue_arbiter
// PURPOSE
//  Shares the single Goldschmidt divide unit between two requesters (port 0/1, e.g. ALU-issue and
//  MDU-replay paths). Round-robin grant, drives the divider Start/Ready handshake, returns
//  {HI=remainder, LO=quotient} tagged to the originator. Handles divide-by-zero locally, supports cancel/drain.
// PARAMETERS
//  TAG_W        4   width of requester tag carried through to the response
//  ZERO_BYPASS  1   1: B==0 answered locally (no divider use); 0: B==0 sent to divider as-is
// PORTS
//  clk          in   1      clock, all state updates on posedge
//  rst          in   1      asynchronous, active-low reset (0 = reset)
//  req_valid    in   2      per-port request valid
//  req_ready    out  2      per-port accept (registered-state decode, no comb path from req_valid)
//  req_signed   in   2      per-port signed (DIV) / unsigned (DIVU)
//  req_a        in   2x32   per-port dividend, {port1,port0}
//  req_b        in   2x32   per-port divisor, {port1,port0}
//  req_tag      in   2xTAG_W per-port tag
//  cancel       in   1      abort in-flight op and discard its result
//  resp_valid   out  1      response valid
//  resp_ready   in   1      response consumer accept
//  resp_id      out  1      port that issued the op
//  resp_tag     out  TAG_W  tag of the op
//  resp_hi      out  32     remainder
//  resp_lo      out  32     quotient
//  resp_dbz     out  1      divide-by-zero flag
//  busy         out  1      state != IDLE
//  div_start    out  1      divider Start, registered
//  div_signed   out  1      divider Signed, registered
//  div_a/div_b  out  32     divider operands, registered, stable while div_start=1
//  div_result   in   64     divider Result {rem,quot}
//  div_ready    in   1      divider Ready
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, all outputs 0 (req_ready=0, resp_*=0, div_*=0, busy=0).
//  States: IDLE, BUSY, DRAIN, RESP.
//  IDLE: req_ready[i]=1 only for granted port, and only when cancel=0. Grant: sole valid port; if both
//   valid, port rr_ptr. On accept (valid&ready at edge): latch id/tag/signed/a/b, rr_ptr<=~granted id.
//   - ZERO_BYPASS=1 and b==0: -> RESP, resp_lo=32'hFFFF_FFFF, resp_hi=a, resp_dbz=1 (1-cycle latency).
//   - else: -> BUSY, div_start<=1, div_a/div_b/div_signed <= request operands.
//  BUSY: div_start held 1 (divider must never see Start drop mid-op; dropping resumes stale iteration).
//   div_ready ignored in the first BUSY cycle (stale Ready from prior op). On div_ready=1:
//   capture resp_hi=div_result[63:32], resp_lo=div_result[31:0], resp_dbz=0, div_start<=0 -> RESP.
//   cancel=1 in BUSY -> DRAIN (start stays 1). cancel and div_ready same edge: result discarded,
//   div_start<=0 -> IDLE.
//  DRAIN: div_start=1 until div_ready=1; then div_start<=0, result discarded -> IDLE. cancel ignored.
//  RESP: resp_valid=1; resp_* stable until resp_ready=1 at an edge -> IDLE. cancel=1 in RESP -> IDLE,
//   resp_valid<=0, response dropped (cancel wins over simultaneous resp_ready).
//  Divider timing with real unit: accept edge N, divider latches N+1, div_ready at N+8,
//   capture N+9: resp_valid from N+9 (9 cycles accept->response). Controller relies only on div_ready,
//   never on a cycle count.
//  Back-to-back: div_start low >=1 full cycle between ops (IDLE/RESP) so divider Ready clears.
//  Reset mid-op: all state cleared immediately; divider is reset by the same reset domain.
// TESTING
//  1 Port0 DIVU a=100,b=7, resp_ready=1 -> resp_valid 9 cycles after accept, lo=14, hi=2, id=0, dbz=0.
//  2 Port1 DIV a=-100,b=7 tag=5 -> lo=32'hFFFF_FFF2(-14), hi=32'hFFFF_FFFE(-2), id=1, tag=5.
//  3 Both ports valid continuously, 4 ops -> grants 0,1,0,1; div_start low >=1 cycle between ops.
//  4 a=123,b=0, ZERO_BYPASS=1 -> resp_valid next cycle, lo=FFFF_FFFF, hi=123, dbz=1, div_start never 1.
//  5 cancel 3 cycles after accept -> div_start stays 1 until div_ready, no resp_valid, then IDLE;
//     next request a=9,b=3 -> lo=3, hi=0.
//  6 resp_ready=0 for 5 cycles -> resp_* stable, req_ready=0; rst=0 in BUSY -> all outputs 0 at once.

Source files
------------

// File: rtl/div_issue_arbiter.sv
// Two-port round-robin front end for the shared Goldschmidt divider.
// Owns the Start/Ready handshake, local divide-by-zero and cancel/drain.
module div_issue_arbiter #(
  parameter int TAG_W       = 4,
  parameter bit ZERO_BYPASS = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [1:0]         req_signed,
  input  logic [63:0]        req_a,
  input  logic [63:0]        req_b,
  input  logic [2*TAG_W-1:0] req_tag,
  input  logic               cancel,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic               resp_id,
  output logic [TAG_W-1:0]   resp_tag,
  output logic [31:0]        resp_hi,
  output logic [31:0]        resp_lo,
  output logic               resp_dbz,
  output logic               busy,
  output logic               div_start,
  output logic               div_signed,
  output logic [31:0]        div_a,
  output logic [31:0]        div_b,
  input  logic [63:0]        div_result,
  input  logic               div_ready
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUSY  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]       r_state;
  logic             r_rr;
  logic [1:0]       r_rdy;
  logic             r_first;
  logic             r_id;
  logic [TAG_W-1:0] r_tag;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic             r_dbz;
  logic             r_rv;
  logic             r_start;
  logic             r_sgn;
  logic [31:0]      r_a;
  logic [31:0]      r_b;

  logic [1:0]       w_nxt;
  logic             w_rr_nxt;
  logic             w_gnt;
  logic             w_acc;
  logic             w_id;
  logic             w_sgn;
  logic [31:0]      w_a;
  logic [31:0]      w_b;
  logic [TAG_W-1:0] w_tag;
  logic             w_zero;
  logic             w_done;

  // The grant is held in r_rdy, so ready never depends on this cycle's valid.
  assign req_ready = r_rdy & {2{~cancel}};
  assign w_acc     = (r_state == S_IDLE) & (|(req_valid & req_ready));
  assign w_id      = r_rdy[1];
  assign w_sgn     = w_id ? req_signed[1] : req_signed[0];
  assign w_a       = w_id ? req_a[63:32] : req_a[31:0];
  assign w_b       = w_id ? req_b[63:32] : req_b[31:0];
  assign w_tag     = w_id ? req_tag[2*TAG_W-1:TAG_W]
                          : req_tag[TAG_W-1:0];
  assign w_zero    = ZERO_BYPASS && (w_b == 32'd0);
  assign w_done    = ~r_first & div_ready;

  assign resp_valid = r_rv;
  assign resp_id    = r_id;
  assign resp_tag   = r_tag;
  assign resp_hi    = r_hi;
  assign resp_lo    = r_lo;
  assign resp_dbz   = r_dbz;
  assign busy       = (r_state != S_IDLE);
  assign div_start  = r_start;
  assign div_signed = r_sgn;
  assign div_a      = r_a;
  assign div_b      = r_b;

  always_comb begin
    w_nxt    = r_state;
    w_rr_nxt = r_rr;
    unique case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          w_nxt    = w_zero ? S_RESP : S_BUSY;
          w_rr_nxt = ~w_id;
        end
      end
      S_BUSY: begin
        if (w_done)
          w_nxt = cancel ? S_IDLE : S_RESP;
        else if (cancel)
          w_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (div_ready)
          w_nxt = S_IDLE;
      end
      S_RESP: begin
        if (cancel || resp_ready)
          w_nxt = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_gnt = w_rr_nxt;
    unique case (1'b1)
      (req_valid == 2'b10): w_gnt = 1'b1;
      (req_valid == 2'b01): w_gnt = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_rr    <= 1'b0;
      r_rdy   <= 2'b00;
      r_first <= 1'b0;
      r_id    <= 1'b0;
      r_tag   <= '0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_dbz   <= 1'b0;
      r_rv    <= 1'b0;
      r_start <= 1'b0;
      r_sgn   <= 1'b0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
    end else begin
      r_state <= w_nxt;
      r_rr    <= w_rr_nxt;
      r_rdy   <= (w_nxt == S_IDLE) ? (w_gnt ? 2'b10 : 2'b01)
                                   : 2'b00;
      r_first <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            r_id  <= w_id;
            r_tag <= w_tag;
            r_sgn <= w_sgn;
            r_a   <= w_a;
            r_b   <= w_b;
            if (w_zero) begin
              r_lo  <= 32'hFFFF_FFFF;
              r_hi  <= w_a;
              r_dbz <= 1'b1;
              r_rv  <= 1'b1;
            end else begin
              r_start <= 1'b1;
              r_first <= 1'b1;
            end
          end
        end
        S_BUSY: begin
          // Ready in the first busy cycle may be left over from the last op.
          if (w_done) begin
            r_start <= 1'b0;
            if (!cancel) begin
              r_hi  <= div_result[63:32];
              r_lo  <= div_result[31:0];
              r_dbz <= 1'b0;
              r_rv  <= 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (div_ready)
            r_start <= 1'b0;
        end
        S_RESP: begin
          if (cancel || resp_ready)
            r_rv <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_issue_arbiter.sv
// Directed bench for div_issue_arbiter with a behavioural
// 8-cycle divider model on the Start/Ready side.
module tb_div_issue_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [1:0]  req_signed = 2'b00;
  logic [63:0] req_a = 64'd0;
  logic [63:0] req_b = 64'd0;
  logic [7:0]  req_tag = 8'd0;
  logic        cancel = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic        resp_id;
  logic [3:0]  resp_tag;
  logic [31:0] resp_hi;
  logic [31:0] resp_lo;
  logic        resp_dbz;
  logic        busy;
  logic        div_start;
  logic        div_signed;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic [63:0] div_result;
  logic        div_ready;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  div_issue_arbiter #(.TAG_W(4), .ZERO_BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_signed(req_signed), .req_a(req_a), .req_b(req_b),
    .req_tag(req_tag), .cancel(cancel),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_tag(resp_tag),
    .resp_hi(resp_hi), .resp_lo(resp_lo), .resp_dbz(resp_dbz),
    .busy(busy), .div_start(div_start), .div_signed(div_signed),
    .div_a(div_a), .div_b(div_b),
    .div_result(div_result), .div_ready(div_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Divider: latches on the edge after Start rises, Ready 7 edges later,
  // Ready held while Start stays high.
  logic        m_run;
  logic [3:0]  m_cnt;
  logic        m_s;
  logic [31:0] m_a, m_b;

  function automatic logic [63:0] fdiv(input logic s,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
    logic [31:0] q, r;
    if (s) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_run <= 1'b0; m_cnt <= 4'd0; div_ready <= 1'b0;
      div_result <= 64'd0; m_s <= 1'b0; m_a <= 32'd0; m_b <= 32'd0;
    end else if (!div_start) begin
      m_run <= 1'b0; div_ready <= 1'b0;
    end else if (!m_run && !div_ready) begin
      m_run <= 1'b1; m_cnt <= 4'd1;
      m_a <= div_a; m_b <= div_b; m_s <= div_signed;
    end else if (m_run) begin
      if (m_cnt == 4'd7) begin
        m_run <= 1'b0; div_ready <= 1'b1;
        div_result <= fdiv(m_s, m_a, m_b);
      end else begin
        m_cnt <= m_cnt + 4'd1;
      end
    end
  end

  task automatic issue(input int p, input logic s,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] tag,
                       output bit ok, output int acc);
    @(negedge clk);
    req_signed[p] = s;
    req_a[p*32 +: 32] = a;
    req_b[p*32 +: 32] = b;
    req_tag[p*4 +: 4] = tag;
    req_valid[p] = 1'b1;
    ok = 1'b0;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      if (req_ready[p]) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) begin
      @(posedge clk);
      #1;
      acc = cyc;
    end
    req_valid[p] = 1'b0;
  endtask

  task automatic wait_resp(output bit ok, output int at);
    ok = 1'b0;
    at = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (resp_valid) begin ok = 1'b1; at = cyc; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({req_ready, resp_valid, busy, div_start} !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_ctl got=%b want=00000",
               {req_ready, resp_valid, busy, div_start});
    end
    n_tests++;
    if ({resp_hi, resp_lo, resp_tag, resp_id, resp_dbz,
         div_a, div_b, div_signed} !== '0) begin
      n_fail++;
      $display("FAIL reset_data got=%h/%h/%h want=0",
               resp_hi, resp_lo, div_a);
    end
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL idle_grant got=%b want=01", req_ready);
    end
  endtask

  task automatic test_divu_port0();
    bit ok, rok;
    int acc, at;
    resp_ready = 1'b1;
    issue(0, 1'b0, 32'd100, 32'd7, 4'd3, ok, acc);
    wait_resp(rok, at);
    n_tests++;
    if (!(ok && rok)) begin
      n_fail++;
      $display("FAIL t1_handshake got=%0d%0d want=11", ok, rok);
    end
    n_tests++;
    if (at - acc !== 9) begin
      n_fail++;
      $display("FAIL t1_latency got=%0d want=9", at - acc);
    end
    n_tests++;
    if ({resp_lo, resp_hi} !== {32'd14, 32'd2}) begin
      n_fail++;
      $display("FAIL t1_data got=%0d/%0d want=14/2", resp_lo, resp_hi);
    end
    n_tests++;
    if ({resp_id, resp_tag, resp_dbz} !== {1'b0, 4'd3, 1'b0}) begin
      n_fail++;
      $display("FAIL t1_meta got=%b/%h/%b want=0/3/0",
               resp_id, resp_tag, resp_dbz);
    end
    @(negedge clk);
    n_tests++;
    if ({resp_valid, busy, div_start} !== 3'b000) begin
      n_fail++;
      $display("FAIL t1_idle got=%b want=000",
               {resp_valid, busy, div_start});
    end
  endtask

  task automatic test_div_port1();
    bit ok, rok;
    int acc, at;
    resp_ready = 1'b1;
    issue(1, 1'b1, 32'hFFFF_FF9C, 32'd7, 4'd5, ok, acc);
    wait_resp(rok, at);
    n_tests++;
    if (!(ok && rok) || {resp_lo, resp_hi} !==
        {32'hFFFF_FFF2, 32'hFFFF_FFFE}) begin
      n_fail++;
      $display("FAIL t2_data got=%h/%h want=fffffff2/fffffffe",
               resp_lo, resp_hi);
    end
    n_tests++;
    if ({resp_id, resp_tag} !== {1'b1, 4'd5}) begin
      n_fail++;
      $display("FAIL t2_meta got=%b/%h want=1/5", resp_id, resp_tag);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int grants, nresp, rises;
    bit prev, stop;
    logic        ids [4];
    logic [31:0] los [4];
    logic [31:0] his [4];
    logic        exp_id [4];
    logic [31:0] exp_lo [4];
    logic [31:0] exp_hi [4];
    exp_id = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_lo = '{32'd10, 32'd15, 32'd10, 32'd15};
    exp_hi = '{32'd3, 32'd1, 32'd3, 32'd1};
    for (int k = 0; k < 4; k++) begin
      ids[k] = 1'bx; los[k] = 'x; his[k] = 'x;
    end
    resp_ready = 1'b1;
    @(negedge clk);
    req_signed = 2'b00;
    req_a = {32'd61, 32'd53};
    req_b = {32'd4, 32'd5};
    req_tag = {4'd1, 4'd0};
    req_valid = 2'b11;
    grants = 0; nresp = 0; rises = 0;
    prev = div_start; stop = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (stop) req_valid = 2'b00;
      if ((req_valid & req_ready) != 2'b00) begin
        grants++;
        if (grants == 4) stop = 1'b1;
      end
      if (resp_valid && nresp < 4) begin
        ids[nresp] = resp_id;
        los[nresp] = resp_lo;
        his[nresp] = resp_hi;
        nresp++;
      end
      if (div_start && !prev) rises++;
      prev = div_start;
      if (nresp == 4) break;
      @(negedge clk);
    end
    req_valid = 2'b00;
    n_tests++;
    if (nresp !== 4) begin
      n_fail++;
      $display("FAIL t3_count got=%0d want=4", nresp);
    end
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if ({ids[k], los[k], his[k]} !== {exp_id[k], exp_lo[k], exp_hi[k]}) begin
        n_fail++;
        $display("FAIL t3_op%0d got=%b/%0d/%0d want=%b/%0d/%0d", k,
                 ids[k], los[k], his[k], exp_id[k], exp_lo[k], exp_hi[k]);
      end
    end
    n_tests++;
    if (rises !== 4) begin
      n_fail++;
      $display("FAIL t3_start_gaps got=%0d want=4", rises);
    end
    @(negedge clk);
  endtask

  task automatic test_zero_bypass();
    bit ok, rok;
    int acc, at;
    resp_ready = 1'b1;
    issue(0, 1'b0, 32'd123, 32'd0, 4'd7, ok, acc);
    n_tests++;
    if (div_start !== 1'b0) begin
      n_fail++;
      $display("FAIL t4_start got=%b want=0", div_start);
    end
    wait_resp(rok, at);
    n_tests++;
    if (!(ok && rok) || at - acc !== 0) begin
      n_fail++;
      $display("FAIL t4_latency got=%0d want=0", at - acc);
    end
    n_tests++;
    if ({resp_lo, resp_hi, resp_dbz, div_start} !==
        {32'hFFFF_FFFF, 32'd123, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL t4_data got=%h/%0d/%b/%b want=ffffffff/123/1/0",
               resp_lo, resp_hi, resp_dbz, div_start);
    end
    @(negedge clk);
  endtask

  task automatic test_cancel();
    bit ok, rok, rv_seen, rdy_seen;
    int acc, at, drop;
    resp_ready = 1'b1;
    issue(0, 1'b0, 32'd500, 32'd9, 4'd2, ok, acc);
    repeat (3) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    rv_seen = 1'b0; rdy_seen = 1'b0; drop = -1;
    for (int i = 0; i < 30; i++) begin
      if (resp_valid) rv_seen = 1'b1;
      if (!div_start) begin drop = cyc; break; end
      if (div_ready) rdy_seen = 1'b1;
      @(negedge clk);
    end
    n_tests++;
    if (!ok || drop !== acc + 9 || !rdy_seen) begin
      n_fail++;
      $display("FAIL t5_drain got=%0d/%b want=%0d/1",
               drop - acc, rdy_seen, 9);
    end
    n_tests++;
    if ({rv_seen, resp_valid, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL t5_no_resp got=%b want=000",
               {rv_seen, resp_valid, busy});
    end
    cancel = 1'b1;
    #1;
    n_tests++;
    if (req_ready !== 2'b00) begin
      n_fail++;
      $display("FAIL t5_cancel_idle got=%b want=00", req_ready);
    end
    cancel = 1'b0;
    issue(0, 1'b0, 32'd9, 32'd3, 4'd4, ok, acc);
    wait_resp(rok, at);
    n_tests++;
    if (!(ok && rok) || {resp_lo, resp_hi, resp_tag} !==
        {32'd3, 32'd0, 4'd4}) begin
      n_fail++;
      $display("FAIL t5_next got=%0d/%0d/%h want=3/0/4",
               resp_lo, resp_hi, resp_tag);
    end
    @(negedge clk);
  endtask

  task automatic test_stall_and_reset();
    bit ok, rok;
    int acc, at, bad, rdy_bad;
    logic [31:0] s_lo, s_hi;
    resp_ready = 1'b0;
    issue(1, 1'b0, 32'd1000, 32'd3, 4'd9, ok, acc);
    wait_resp(rok, at);
    s_lo = resp_lo; s_hi = resp_hi;
    req_valid[0] = 1'b1;
    bad = 0; rdy_bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (!resp_valid || resp_lo !== s_lo || resp_hi !== s_hi ||
          resp_tag !== 4'd9 || resp_id !== 1'b1) bad++;
      if (req_ready !== 2'b00) rdy_bad++;
    end
    req_valid[0] = 1'b0;
    n_tests++;
    if (!(ok && rok) || {s_lo, s_hi} !== {32'd333, 32'd1}) begin
      n_fail++;
      $display("FAIL t6_data got=%0d/%0d want=333/1", s_lo, s_hi);
    end
    n_tests++;
    if (bad !== 0 || rdy_bad !== 0) begin
      n_fail++;
      $display("FAIL t6_stall got=%0d/%0d want=0/0", bad, rdy_bad);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL t6_release got=%b want=0", resp_valid);
    end
    issue(0, 1'b1, 32'd77, 32'd7, 4'd1, ok, acc);
    repeat (3) @(negedge clk);
    n_tests++;
    if ({ok, busy, div_start, div_signed} !== 4'b1111) begin
      n_fail++;
      $display("FAIL t6_pre got=%b want=1111",
               {ok, busy, div_start, div_signed});
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if ({req_ready, resp_valid, resp_id, resp_tag, resp_hi, resp_lo,
         resp_dbz, busy, div_start, div_signed, div_a, div_b} !== '0) begin
      n_fail++;
      $display("FAIL t6_reset got=%b%b%b/%h/%h want=0", busy, div_start,
               div_signed, div_a, div_b);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_divu_port0();
    test_div_port1();
    test_back_to_back();
    test_zero_bypass();
    test_cancel();
    test_stall_and_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
